// File: rtl/motor_pkg.sv
// motor_pkg: shared constants, direction type and decode helper for the
// motor_meter drive-bus monitor.
//   PWM_PERIOD / PWM_BITS : measurement window length and counter width
//   EN1..EN2              : bit positions on the 6-bit drive bus
//   dir_t / decode_dir    : ina/inb pair to direction (FWD, REV, BAD)
package motor_pkg;

  localparam int PWM_PERIOD = 256;
  localparam int PWM_BITS   = 8;

  // Drive bus layout {en1, ina1, inb1, ina2, inb2, en2}
  localparam int EN1  = 5;
  localparam int INA1 = 4;
  localparam int INB1 = 3;
  localparam int INA2 = 2;
  localparam int INB2 = 1;
  localparam int EN2  = 0;

  typedef enum logic [1:0] {
    DIR_FWD = 2'd0,
    DIR_REV = 2'd1,
    DIR_BAD = 2'd2
  } dir_t;

  function automatic dir_t decode_dir(input logic ina, input logic inb);
    case ({ina, inb})
      2'b10:   return DIR_FWD;
      2'b01:   return DIR_REV;
      default: return DIR_BAD;
    endcase
  endfunction

endpackage

// File: rtl/motor_meter_if.sv
// motor_meter_if: drive-bus tap input plus the measurement result bundle.
//   motor_in       : sampled drive bus {en1, ina1, inb1, ina2, inb2, en2}
//   level1/2_out   : signed per-motor levels (-255..+255)
//   speed/turn_est : reconstructed speed/turn pair
//   fault/dir_change/sat_out : per-motor flags {m1, m2}
//   valid_out      : one-cycle strobe when all results update
// Handshake: valid_out is a pure strobe with no ready; results are stable
// between strobes and the consumer must capture on the strobe cycle.
// master = the side driving the bus and reading results; slave = the meter.
interface motor_meter_if;
  logic        [5:0] motor_in;
  logic signed [8:0] level1_out;
  logic signed [8:0] level2_out;
  logic signed [8:0] speed_est_out;
  logic signed [9:0] turn_est_out;
  logic        [1:0] fault_out;
  logic        [1:0] dir_change_out;
  logic        [1:0] sat_out;
  logic              valid_out;

  modport master (
    output motor_in,
    input  level1_out, level2_out, speed_est_out, turn_est_out,
    input  fault_out, dir_change_out, sat_out, valid_out
  );

  modport slave (
    input  motor_in,
    output level1_out, level2_out, speed_est_out, turn_est_out,
    output fault_out, dir_change_out, sat_out, valid_out
  );
endinterface

// File: rtl/motor_chan_meter.sv
// motor_chan_meter: one H-bridge channel of the meter.
//   clk_in, rst_in : clock, synchronous active-high reset
//   term_in        : high on the cycle sampling the last slot of a window
//   en_in, ina_in, inb_in : channel samples
//   level_out      : registered signed level of the last finished window
//   level_nxt_out  : level the window would produce if it ended this cycle
//                    (used by the top to register estimates on the same edge)
//   fault_out, dir_change_out, sat_out : registered per-window flags
module motor_chan_meter
  import motor_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              term_in,
  input  logic              en_in,
  input  logic              ina_in,
  input  logic              inb_in,
  output logic signed [8:0] level_out,
  output logic signed [8:0] level_nxt_out,
  output logic              fault_out,
  output logic              dir_change_out,
  output logic              sat_out
);

  logic [8:0] hcnt_q, hcnt_d;
  logic       fault_q, fault_d;
  logic       seen_q, seen_d;
  logic       chg_q, chg_d;
  dir_t       first_q, first_d;
  dir_t       last_q, last_d;
  dir_t       dir;
  logic       fault_fin;
  logic [7:0] mag;

  // Accumulator update including the current sample, so the final sample
  // of a window is folded in on the same edge that closes the window.
  always_comb begin
    dir     = decode_dir(ina_in, inb_in);
    hcnt_d  = hcnt_q + {8'd0, en_in};
    fault_d = fault_q;
    seen_d  = seen_q;
    chg_d   = chg_q;
    first_d = first_q;
    last_d  = last_q;
    if (dir == DIR_BAD) begin
      fault_d = 1'b1;
    end else begin
      if (!seen_q) begin
        seen_d  = 1'b1;
        first_d = dir;
      end else if (dir != first_q) begin
        chg_d = 1'b1;
      end
      last_d = dir;
    end
    // A window with no valid direction at all cannot be signed: fault it.
    fault_fin = fault_d | ~seen_d;
    // hcnt can only reach 256 when every sample had enable high.
    mag = hcnt_d[8] ? 8'hFF : hcnt_d[7:0];
    if (fault_fin) begin
      level_nxt_out = '0;
    end else if (last_d == DIR_REV) begin
      level_nxt_out = -$signed({1'b0, mag});
    end else begin
      level_nxt_out = $signed({1'b0, mag});
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hcnt_q         <= '0;
      fault_q        <= 1'b0;
      seen_q         <= 1'b0;
      chg_q          <= 1'b0;
      first_q        <= DIR_FWD;
      last_q         <= DIR_FWD;
      level_out      <= '0;
      fault_out      <= 1'b0;
      dir_change_out <= 1'b0;
      sat_out        <= 1'b0;
    end else if (term_in) begin
      hcnt_q         <= '0;
      fault_q        <= 1'b0;
      seen_q         <= 1'b0;
      chg_q          <= 1'b0;
      first_q        <= DIR_FWD;
      last_q         <= DIR_FWD;
      level_out      <= level_nxt_out;
      fault_out      <= fault_fin;
      dir_change_out <= chg_d;
      sat_out        <= hcnt_d[8];
    end else begin
      hcnt_q  <= hcnt_d;
      fault_q <= fault_d;
      seen_q  <= seen_d;
      chg_q   <= chg_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/motor_meter.sv
// motor_meter: closed-loop monitor for the two-channel H-bridge drive bus.
// Counts enable-high cycles per motor over fixed 256-cycle windows and
// reports signed levels, speed/turn estimates and per-window flags once
// per window.
//   SYNC_STAGES : input synchronizer depth (0 = same-domain loopback)
//   clk_in      : system clock
//   rst_in      : synchronous active-high reset
//   bus         : motor_meter_if slave (motor_in in, results out)
module motor_meter
  import motor_pkg::*;
#(
  parameter int SYNC_STAGES = 0
) (
  input  logic          clk_in,
  input  logic          rst_in,
  motor_meter_if.slave  bus
);

  logic [5:0] sample;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sample = bus.motor_in;
    end else begin : g_sync
      logic [5:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= bus.motor_in;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign sample = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Window counter only; strobe timing does not depend on sync depth.
  logic [PWM_BITS-1:0] wcnt_q;
  logic                term;

  assign term = (wcnt_q == PWM_BITS'(PWM_PERIOD - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) wcnt_q <= '0;
    else        wcnt_q <= wcnt_q + 1'b1;
  end

  logic signed [8:0] l1_q, l1_nxt, l2_q, l2_nxt;
  logic              f1, f2, c1, c2, s1, s2;

  motor_chan_meter u_m1 (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .term_in        (term),
    .en_in          (sample[EN1]),
    .ina_in         (sample[INA1]),
    .inb_in         (sample[INB1]),
    .level_out      (l1_q),
    .level_nxt_out  (l1_nxt),
    .fault_out      (f1),
    .dir_change_out (c1),
    .sat_out        (s1)
  );

  motor_chan_meter u_m2 (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .term_in        (term),
    .en_in          (sample[EN2]),
    .ina_in         (sample[INA2]),
    .inb_in         (sample[INB2]),
    .level_out      (l2_q),
    .level_nxt_out  (l2_nxt),
    .fault_out      (f2),
    .dir_change_out (c2),
    .sat_out        (s2)
  );

  // Estimates from the levels being registered on this same edge.
  logic signed [9:0] sum_nxt, diff_nxt;
  logic signed [8:0] speed_q;
  logic signed [9:0] turn_q;
  logic              valid_q;

  assign sum_nxt  = {l1_nxt[8], l1_nxt} + {l2_nxt[8], l2_nxt};
  assign diff_nxt = {l2_nxt[8], l2_nxt} - {l1_nxt[8], l1_nxt};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      speed_q <= '0;
      turn_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= term;
      if (term) begin
        // Dropping the LSB of the sign-extended sum is the arithmetic >>> 1.
        speed_q <= sum_nxt[9:1];
        turn_q  <= diff_nxt;
      end
    end
  end

  assign bus.level1_out     = l1_q;
  assign bus.level2_out     = l2_q;
  assign bus.speed_est_out  = speed_q;
  assign bus.turn_est_out   = turn_q;
  assign bus.fault_out      = {f1, f2};
  assign bus.dir_change_out = {c1, c2};
  assign bus.sat_out        = {s1, s2};
  assign bus.valid_out      = valid_q;

endmodule

// File: tb/tb_motor_meter.sv
// tb_motor_meter: self-checking bench for motor_meter (SYNC_STAGES = 0).
module tb_motor_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  motor_meter_if bus();

  motor_meter #(.SYNC_STAGES(0)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [5:0] win_buf [256];

  typedef struct {
    int l1;  int l2;
    int e_l1; int e_l2; int e_sp; int e_tu;
    int e_flt; int e_chg; int e_sat;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_results(input string tag, input int l1, input int l2,
                               input int sp, input int tu, input int flt,
                               input int chg, input int sat);
    check({tag, ".level1"}, int'($signed(bus.level1_out)), l1);
    check({tag, ".level2"}, int'($signed(bus.level2_out)), l2);
    check({tag, ".speed"},  int'($signed(bus.speed_est_out)), sp);
    check({tag, ".turn"},   int'($signed(bus.turn_est_out)), tu);
    check({tag, ".fault"},  int'(bus.fault_out), flt);
    check({tag, ".dirchg"}, int'(bus.dir_change_out), chg);
    check({tag, ".sat"},    int'(bus.sat_out), sat);
  endtask

  // PWM drive model: enable high for |L| slots from window start, sign sets direction.
  function automatic logic [5:0] pwm_word(input int i, input int l1, input int l2);
    logic en1, en2;
    logic [1:0] d1, d2;
    en1 = (i < ((l1 < 0) ? -l1 : l1));
    en2 = (i < ((l2 < 0) ? -l2 : l2));
    d1  = (l1 < 0) ? 2'b01 : 2'b10;
    d2  = (l2 < 0) ? 2'b01 : 2'b10;
    return {en1, d1, d2, en2};
  endfunction

  task automatic fill_pwm(input int l1, input int l2);
    for (int i = 0; i < 256; i++) win_buf[i] = pwm_word(i, l1, l2);
  endtask

  // Reference: count enables, list valid directions, judge the window.
  task automatic model_chan(input int ch, output int lvl, output int flt,
                            output int chg, output int sat);
    int en_b, a_b, b_b, hc, mag;
    int dq[$];
    bit bad;
    en_b = (ch == 1) ? 5 : 0;
    a_b  = (ch == 1) ? 4 : 2;
    b_b  = (ch == 1) ? 3 : 1;
    hc = 0; bad = 0; dq.delete();
    for (int i = 0; i < 256; i++) begin
      hc += int'(win_buf[i][en_b]);
      if (win_buf[i][a_b] == win_buf[i][b_b]) bad = 1;
      else dq.push_back(win_buf[i][a_b] ? 1 : -1);
    end
    flt = (bad || dq.size() == 0) ? 1 : 0;
    chg = 0;
    foreach (dq[k]) if (dq[k] != dq[0]) chg = 1;
    sat = (hc == 256) ? 1 : 0;
    mag = (hc > 255) ? 255 : hc;
    if (flt == 1) lvl = 0;
    else lvl = (dq[dq.size()-1] < 0) ? -mag : mag;
  endtask

  task automatic model_check(input string tag);
    int l1, f1, c1, s1, l2, f2, c2, s2;
    model_chan(1, l1, f1, c1, s1);
    model_chan(2, l2, f2, c2, s2);
    check_results(tag, l1, l2, (l1 + l2) >>> 1, l2 - l1,
                  f1 * 2 + f2, c1 * 2 + c2, s1 * 2 + s2);
  endtask

  // Drive one full window; strobe must appear only after the last sample.
  task automatic drive_window(input string tag);
    int early;
    early = 0;
    for (int i = 0; i < 256; i++) begin
      bus.motor_in = win_buf[i];
      @(posedge clk);
      #1;
      if (i < 255 && bus.valid_out) early++;
    end
    check({tag, ".early_strobe"}, early, 0);
    check({tag, ".valid"}, int'(bus.valid_out), 1);
  endtask

  initial begin
    int mode, a, b, split;
    bus.motor_in = '0;

    vecs[0] = '{80, 120, 80, 120, 100, 40, 0, 0, 0};
    vecs[1] = '{80, 120, 80, 120, 100, 40, 0, 0, 0};
    vecs[2] = '{-200, -200, -200, -200, -200, 0, 0, 0, 0};
    vecs[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{-1, 37, -1, 37, 18, 38, 0, 0, 0};
    vecs[5] = '{-3, 0, -3, 0, -2, 3, 0, 0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_results("reset", 0, 0, 0, 0, 0, 0, 0);
    check("reset.valid", int'(bus.valid_out), 0);

    // Table: back-to-back windows, strobes at 256, 512, ...
    for (int v = 0; v < 6; v++) begin
      fill_pwm(vecs[v].l1, vecs[v].l2);
      drive_window($sformatf("vec%0d", v));
      check_results($sformatf("vec%0d", v), vecs[v].e_l1, vecs[v].e_l2,
                    vecs[v].e_sp, vecs[v].e_tu, vecs[v].e_flt,
                    vecs[v].e_chg, vecs[v].e_sat);
    end

    // Motor 1 enable forced high all window
    for (int i = 0; i < 256; i++) win_buf[i] = 6'b110100;
    drive_window("sat");
    check_results("sat", 255, 0, 127, -255, 0, 0, 2);

    // Motor 2: REV with 50 enables in first half, FWD enable low after
    for (int i = 0; i < 256; i++) begin
      if (i < 128) win_buf[i] = {1'b0, 2'b10, 2'b01, (i < 50) ? 1'b1 : 1'b0};
      else         win_buf[i] = {1'b0, 2'b10, 2'b10, 1'b0};
    end
    drive_window("dirchg");
    check_results("dirchg", 0, 50, 25, 50, 0, 1, 0);

    // Motor 1 one invalid sample; motor 2 never a valid direction
    for (int i = 0; i < 256; i++) begin
      win_buf[i] = {(i < 100) ? 1'b1 : 1'b0, (i == 0) ? 2'b11 : 2'b10, 2'b00, 1'b0};
    end
    drive_window("fault");
    check_results("fault", 0, 0, 0, 0, 3, 0, 0);
    fill_pwm(30, 30);
    drive_window("clean");
    check_results("clean", 30, 30, 30, 0, 0, 0, 0);

    // Reset with wcnt = 130: partial window of full enables is discarded
    for (int i = 0; i < 130; i++) begin
      bus.motor_in = 6'b110101;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_results("midrst", 0, 0, 0, 0, 0, 0, 0);
    check("midrst.valid", int'(bus.valid_out), 0);
    fill_pwm(10, -20);
    drive_window("postrst");
    check_results("postrst", 10, -20, -5, -30, 0, 0, 0);

    // Randomized windows against the reference model
    for (int r = 0; r < 10; r++) begin
      mode = $urandom_range(0, 2);
      a = $urandom_range(0, 510) - 255;
      b = $urandom_range(0, 510) - 255;
      split = $urandom_range(1, 255);
      for (int i = 0; i < 256; i++) begin
        case (mode)
          0:       win_buf[i] = pwm_word(i, a, b);
          1:       win_buf[i] = 6'($urandom_range(0, 63));
          default: win_buf[i] = (i < split) ? pwm_word(i, a, b) : pwm_word(i, b, -a);
        endcase
      end
      drive_window($sformatf("rand%0d", r));
      model_check($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
